demo_diagnostic_button_pio: RTL and testbench
=============================================

Name: demo_diagnostic_button_pio

Overview:
Avalon-MM slave input PIO for the diagnostic board's push-buttons and switches; the input-side counterpart of the LED output PIO. Samples external pins through a synchronizer and per-bit debouncer, detects edges, latches them in a write-1-to-clear edge-capture register, and raises a maskable interrupt to the Nios II. Sits on the system interconnect beside the LED PIO, with the same 3-bit address and 32-bit data bus.

Parameters:
WIDTH, 8, number of input pins (1..32)
SYNC_STAGES, 2, synchronizer flop depth (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced value changes (>=1)
EDGE_TYPE, 0, edges captured: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external pins
readdata  out  32  registered read data
irq  out  1  interrupt request, active-high, level

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state is reset asynchronously and released synchronously to clk.
- Reset values: sync chain, debounced value d, previous value d_prev, debounce counters, edge_capture, irq_mask, readdata, irq all 0.
- Register map (word addresses):
  - 0 DATA: RO, d[WIDTH-1:0], upper bits 0; writes ignored.
  - 2 IRQMASK: RW, WIDTH bits.
  - 3 EDGECAPTURE: read returns edge_capture; a write clears each bit whose writedata bit is 1.
  - 1, 4-7: read 0, writes ignored.
- wr_strobe = chipselect & ~write_n. No wait states.
- Read: readdata <= mux(address) every clk, independent of chipselect. Read latency is 1 cycle.
- Synchronizer: in_port passes through SYNC_STAGES flops to produce s.
- Debounce, per bit i, with counter width clog2(DEBOUNCE_CYCLES):
  - s[i]==d[i]: cnt[i] <= 0.
  - s[i]!=d[i] and cnt[i]==DEBOUNCE_CYCLES-1: d[i] <= s[i], cnt[i] <= 0.
  - otherwise: cnt[i] <= cnt[i]+1.
  - Any return of s[i] to d[i] before the terminal count restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Pin-to-d latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles. DEBOUNCE_CYCLES=1 means a one-cycle follow.
- Edge detect: d_prev <= d every cycle.
  - ev = d&~d_prev (EDGE_TYPE 0), ~d&d_prev (1), or d^d_prev (2).
- Edge capture, per bit: edge_capture[i] <= ev[i] | (edge_capture[i] & ~clr[i]).
  - clr = wr_strobe & (address==3) ? writedata : 0.
  - A set and a clear in the same cycle: set wins, bit stays 1.
- irq <= |(edge_capture & irq_mask), registered, one cycle after the capture or mask change.
- An input that idles high rises from the reset value 0 and captures one rising edge after reset (SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles). This is intended: software clears EDGECAPTURE before unmasking.
- Reset asserted mid-debounce or mid-capture: all state returns to 0 immediately, and pending edges are lost.

Test Plan:
- Reset: WIDTH=8, DEBOUNCE_CYCLES=4, in_port=0x00, release reset_n -> readdata=0 on reads of addresses 0-7, irq=0.
- Glitch rejection: in_port bit0 high for 3 cycles then low -> DATA stays 0x00, EDGECAPTURE stays 0x00. Bit0 held high -> DATA=0x01 exactly 2+4 cycles after the pin change; EDGECAPTURE=0x01 one cycle later.
- Interrupt/mask: IRQMASK=0x00 with EDGECAPTURE=0x01 -> irq=0. Write IRQMASK=0x01 -> irq=1 one cycle after the write; readback of addr 2 = 0x00000001.
- Write-1-clear: EDGECAPTURE=0x05, write 0x04 to addr 3 -> reads 0x01; write 0xFFFFFFFF -> reads 0x00, irq=0 next cycle.
- Set/clear collision: schedule a clear write to addr 3 (writedata=0x02) in the same cycle as a bit1 debounced rising edge -> EDGECAPTURE bit1 reads 1.
- EDGE_TYPE=1 build: bit3 debounced 1->0 -> EDGECAPTURE=0x08. A 0->1 transition leaves it unchanged. Reset mid-count (cnt=2) -> counter 0, DATA=0x00 after release.

Source files
------------

// File: rtl/demo_diagnostic_button_pio.sv
// Avalon-MM input PIO for push-buttons/switches: synchronizer, per-bit debouncer,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module demo_diagnostic_button_pio #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // A one-cycle debounce still needs a 1-bit counter that never leaves zero.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr;
    logic             wr_strobe;
    logic [31:0]      d_ext;
    logic [31:0]      mask_ext;
    logic [31:0]      cap_ext;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample agreeing with d restarts the count, so only an unbroken run
    // of DEBOUNCE_CYCLES disagreeing samples moves d.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev <= '0;
        end else begin
            d_prev <= d;
        end
    end

    always_comb begin
        ev = d ^ d_prev;
        case (EDGE_TYPE)
            0:       ev = d & ~d_prev;
            1:       ev = ~d & d_prev;
            default: ev = d ^ d_prev;
        endcase
    end

    assign wr_strobe = chipselect & ~write_n;
    assign clr = (wr_strobe && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as a clear leaves the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= ev | (edge_capture & ~clr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_strobe && address == ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        d_ext                = '0;
        mask_ext             = '0;
        cap_ext              = '0;
        d_ext[WIDTH-1:0]     = d;
        mask_ext[WIDTH-1:0]  = irq_mask;
        cap_ext[WIDTH-1:0]   = edge_capture;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next = d_ext;
            ADDR_IRQMASK: rd_next = mask_ext;
            ADDR_EDGECAP: rd_next = cap_ext;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_demo_diagnostic_button_pio.sv
// Bench for demo_diagnostic_button_pio: a rising-edge and a falling-edge build
// share one bus and pin set and are checked against a windowed reference model.
module tb_demo_diagnostic_button_pio;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  rd0, rd1;
    logic         irq0, irq1;

    int n_checks = 0;
    int n_fail   = 0;

    demo_diagnostic_button_pio #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    demo_diagnostic_button_pio #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pin history is a plain delay line; d flips once the
    // last D synchronized samples all disagree with it.
    logic [W-1:0] m_sync [S];
    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_d, m_dp, m_mask;
    logic [W-1:0] m_cap [2];
    logic         m_irq [2];
    logic [31:0]  m_rd  [2];

    task automatic model_reset();
        for (int k = 0; k < S; k++) m_sync[k] = '0;
        m_hist.delete();
        m_d = '0; m_dp = '0; m_mask = '0;
        for (int e = 0; e < 2; e++) begin
            m_cap[e] = '0; m_irq[e] = 1'b0; m_rd[e] = '0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] s_old, d_new, clr, ev;
        logic [31:0]  rd;
        bit           all_diff;
        s_old = m_sync[S-1];
        for (int k = S-1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = in_port;
        m_hist.push_back(s_old);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        d_new = m_d;
        if (m_hist.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][i] == m_d[i]) all_diff = 1'b0;
                if (all_diff) d_new[i] = ~m_d[i];
            end
        end
        clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
        for (int e = 0; e < 2; e++) begin
            ev = (e == 0) ? (m_d & ~m_dp) : (~m_d & m_dp);
            case (address)
                3'd0:    rd = {24'd0, m_d};
                3'd2:    rd = {24'd0, m_mask};
                3'd3:    rd = {24'd0, m_cap[e]};
                default: rd = 32'd0;
            endcase
            m_rd[e]  = rd;
            m_irq[e] = |(m_cap[e] & m_mask);
            m_cap[e] = ev | (m_cap[e] & ~clr);
        end
        if (chipselect && !write_n && address == 3'd2) m_mask = writedata[W-1:0];
        m_dp = m_d;
        m_d  = d_new;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_rd_rise",  rd0,  m_rd[0]);
            check("model_rd_fall",  rd1,  m_rd[1]);
            check("model_irq_rise", {31'd0, irq0}, {31'd0, m_irq[0]});
            check("model_irq_fall", {31'd0, irq1}, {31'd0, m_irq[1]});
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        address = a; writedata = wd; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r1);
        @(negedge clk);
        address = a;
        @(negedge clk);
        r0 = rd0; r1 = rd1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] r0, r1;

    initial begin
        wait_cycles(3);
        #2 reset_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            bus_read(a[2:0], r0, r1);
            check($sformatf("reset_read_a%0d", a), r0, 32'd0);
        end
        check("reset_irq", {31'd0, irq0}, 32'd0);

        // Three-cycle glitch on bit0 must not reach d.
        @(negedge clk);
        in_port = 8'h01;
        wait_cycles(3);
        in_port = 8'h00;
        wait_cycles(8);
        bus_read(3'd0, r0, r1);
        check("glitch_data", r0, 32'd0);
        bus_read(3'd3, r0, r1);
        check("glitch_cap", r0, 32'd0);

        // d moves S+D edges after the pin; readdata shows it one edge later.
        @(negedge clk);
        address = 3'd0;
        in_port = 8'h01;
        wait_cycles(6);
        check("data_before", rd0, 32'd0);
        @(negedge clk);
        check("data_after", rd0, 32'h01);
        address = 3'd3;
        @(negedge clk);
        check("cap_rise", rd0, 32'h01);
        check("cap_fall_none", rd1, 32'h00);

        check("irq_masked", {31'd0, irq0}, 32'd0);
        bus_write(3'd2, 32'h01);
        @(negedge clk);
        check("irq_unmasked", {31'd0, irq0}, 32'd1);
        check("irq_fall_idle", {31'd0, irq1}, 32'd0);
        bus_read(3'd2, r0, r1);
        check("mask_readback", r0, 32'h01);

        @(negedge clk);
        in_port = 8'h05;
        wait_cycles(10);
        bus_read(3'd3, r0, r1);
        check("cap_05", r0, 32'h05);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, r0, r1);
        check("w1c_partial", r0, 32'h01);
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_read(3'd3, r0, r1);
        check("w1c_all", r0, 32'h00);
        check("irq_cleared", {31'd0, irq0}, 32'd0);

        // Clear write lands on the edge that sets bit1.
        @(negedge clk);
        in_port = 8'h07;
        wait_cycles(5);
        bus_write(3'd3, 32'h02);
        bus_read(3'd3, r0, r1);
        check("collision_set_wins", r0, 32'h02);

        bus_write(3'd3, 32'hFF);
        @(negedge clk);
        in_port = 8'h0F;
        wait_cycles(10);
        bus_read(3'd3, r0, r1);
        check("fall_ignores_rise", r1, 32'h00);
        @(negedge clk);
        in_port = 8'h07;
        wait_cycles(10);
        bus_read(3'd3, r0, r1);
        check("fall_bit3", r1, 32'h08);

        // Reset while bit4's counter sits at 2.
        @(negedge clk);
        in_port = 8'h17;
        wait_cycles(4);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        check("reset_mid_irq", {31'd0, irq0}, 32'd0);
        bus_read(3'd0, r0, r1);
        check("reset_mid_data", r0, 32'd0);
        bus_read(3'd3, r0, r1);
        check("reset_mid_cap", r1, 32'd0);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W-1));
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        wait_cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
